// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, branch flush and
// saturating stall/flush event counters for performance debug.
module if_id_stage #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,          // active-low asynchronous reset
  input  logic [31:0]      pc_i,
  input  logic [31:0]      inst_i,
  input  logic             flush_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_rt_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      inst_o,
  output logic             valid_o,
  output logic [4:0]       rs_o,
  output logic [4:0]       rt_o,
  output logic [4:0]       rd_o,
  output logic [15:0]      imm_o,
  output logic             hazard_o,
  output logic             PCWrite_o,
  output logic             bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [31:0]      pc_q,        pc_d;
  logic [31:0]      inst_q,      inst_d;
  logic             valid_q,     valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hazard;

  // Register fields are plain slices of the held instruction word.
  assign rs_o  = inst_q[25:21];
  assign rt_o  = inst_q[20:16];
  assign rd_o  = inst_q[15:11];
  assign imm_o = inst_q[15:0];

  // Load-use: the load in ID/EX writes a register the instruction in ID reads.
  // rt is compared for every instruction type; an occasional needless stall
  // is cheaper than decoding the opcode here.
  assign hazard = IDEX_MemRead_i & valid_q & (IDEX_rt_i != 5'd0) &
                  ((IDEX_rt_i == inst_q[25:21]) | (IDEX_rt_i == inst_q[20:16]));

  assign hazard_o    = hazard;
  assign PCWrite_o   = ~hazard;
  assign bubble_o    = hazard | ~valid_q;
  assign pc_o        = pc_q;
  assign inst_o      = inst_q;
  assign valid_o     = valid_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  // Next-state selection with priority hazard > flush > normal advance.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pc_d        = pc_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (hazard) begin
      // Hold everything; a concurrent flush is dropped because the branch in
      // ID compared stale operands and will re-resolve next cycle.
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end else if (flush_i) begin
      pc_d    = pc_i;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end else begin
      pc_d    = pc_i;
      inst_d  = inst_i;
      valid_d = 1'b1;
    end
  end

  // State registers; reset clears immediately regardless of the clock.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q        <= 32'h0;
      inst_q      <= NOP_INST;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // values sampled before the edge.
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, capture, load-use stall, rt=0 case,
// flush, flush under hazard, counter saturation and asynchronous reset pulse.
module tb_if_id_stage;

  localparam int CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [31:0]      pc_i;
  logic [31:0]      inst_i;
  logic             flush_i;
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_rt_i;
  logic [31:0]      pc_o;
  logic [31:0]      inst_o;
  logic             valid_o;
  logic [4:0]       rs_o, rt_o, rd_o;
  logic [15:0]      imm_o;
  logic             hazard_o, PCWrite_o, bubble_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  if_id_stage #(.CNT_W(CNT_W), .NOP_INST(32'h0000_0000)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pc_i           (pc_i),
    .inst_i         (inst_i),
    .flush_i        (flush_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_rt_i      (IDEX_rt_i),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .valid_o        (valid_o),
    .rs_o           (rs_o),
    .rt_o           (rt_o),
    .rd_o           (rd_o),
    .imm_o          (imm_o),
    .hazard_o       (hazard_o),
    .PCWrite_o      (PCWrite_o),
    .bubble_o       (bubble_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; pc_i = 32'h0; inst_i = 32'h0; flush_i = 1'b0;
    IDEX_MemRead_i = 1'b0; IDEX_rt_i = 5'd0;
    #2;
    check("rst_pc",      pc_o,        32'h0);
    check("rst_inst",    inst_o,      32'h0);
    check("rst_valid",   valid_o,     32'h0);
    check("rst_bubble",  bubble_o,    32'h1);
    check("rst_pcwrite", PCWrite_o,   32'h1);
    check("rst_stall",   stall_cnt_o, 32'h0);
    check("rst_flush",   flush_cnt_o, 32'h0);

    // Release reset between edges; nothing captured until the next edge.
    step(); step();
    pc_i = 32'h4; inst_i = 32'h8C22_0000; rst_i = 1'b1;
    #1;
    check("pre_valid",  valid_o,  32'h0);
    check("pre_inst",   inst_o,   32'h0);
    check("pre_bubble", bubble_o, 32'h1);
    step();
    check("cap_pc",     pc_o,     32'h4);
    check("cap_inst",   inst_o,   32'h8C22_0000);
    check("cap_valid",  valid_o,  32'h1);
    check("cap_rs",     rs_o,     32'd1);
    check("cap_rt",     rt_o,     32'd2);
    check("cap_imm",    imm_o,    32'h0);
    check("cap_bubble", bubble_o, 32'h0);

    // add $1,$2,$3 into ID, then a load to $2 in ID/EX.
    pc_i = 32'h8; inst_i = 32'h0043_0820;
    step();
    check("add_rs", rs_o, 32'd2);
    check("add_rt", rt_o, 32'd3);
    check("add_rd", rd_o, 32'd1);
    IDEX_MemRead_i = 1'b1; IDEX_rt_i = 5'd2;
    pc_i = 32'hC; inst_i = 32'h1234_5678;
    #1;
    check("lu_hazard",  hazard_o,  32'h1);
    check("lu_pcwrite", PCWrite_o, 32'h0);
    check("lu_bubble",  bubble_o,  32'h1);
    step();
    check("lu_inst_hold", inst_o,      32'h0043_0820);
    check("lu_pc_hold",   pc_o,        32'h8);
    check("lu_stall",     stall_cnt_o, 32'd1);
    IDEX_MemRead_i = 1'b0;
    #1;
    check("lu_clear",   hazard_o,  32'h0);
    check("lu_pcw_on",  PCWrite_o, 32'h1);
    step();
    check("lu_adv_inst", inst_o, 32'h1234_5678);
    check("lu_adv_pc",   pc_o,   32'hC);

    // rs=0 instruction in ID, load targeting $0: no hazard.
    pc_i = 32'h10; inst_i = 32'h0003_0820;
    step();
    IDEX_MemRead_i = 1'b1; IDEX_rt_i = 5'd0;
    pc_i = 32'h14; inst_i = 32'hAABB_CCDD;
    #1;
    check("rt0_hazard", hazard_o, 32'h0);
    step();
    check("rt0_inst",  inst_o,      32'hAABB_CCDD);
    check("rt0_stall", stall_cnt_o, 32'd1);

    // Flush with no hazard.
    IDEX_MemRead_i = 1'b0; flush_i = 1'b1;
    pc_i = 32'h18; inst_i = 32'h2001_0005;
    step();
    check("fl_inst",   inst_o,      32'h0);
    check("fl_valid",  valid_o,     32'h0);
    check("fl_pc",     pc_o,        32'h18);
    check("fl_cnt",    flush_cnt_o, 32'd1);
    check("fl_bubble", bubble_o,    32'h1);

    // Flush together with hazard: hazard wins.
    flush_i = 1'b0; pc_i = 32'h1C; inst_i = 32'h0043_0820;
    step();
    IDEX_MemRead_i = 1'b1; IDEX_rt_i = 5'd3; flush_i = 1'b1;
    pc_i = 32'h20; inst_i = 32'hDEAD_BEEF;
    #1;
    check("fh_hazard", hazard_o, 32'h1);
    step();
    check("fh_pc",    pc_o,        32'h1C);
    check("fh_inst",  inst_o,      32'h0043_0820);
    check("fh_valid", valid_o,     32'h1);
    check("fh_flush", flush_cnt_o, 32'd1);
    check("fh_stall", stall_cnt_o, 32'd2);

    // Hold the hazard long enough to saturate the stall counter.
    flush_i = 1'b0;
    repeat (65540) step();
    check("sat_stall", stall_cnt_o, 32'h0000_FFFF);
    check("sat_flush", flush_cnt_o, 32'd1);
    check("sat_inst",  inst_o,      32'h0043_0820);

    // Reset pulse between edges clears everything at once.
    rst_i = 1'b0;
    #1;
    check("ar_pc",     pc_o,        32'h0);
    check("ar_inst",   inst_o,      32'h0);
    check("ar_valid",  valid_o,     32'h0);
    check("ar_stall",  stall_cnt_o, 32'h0);
    check("ar_flush",  flush_cnt_o, 32'h0);
    check("ar_hazard", hazard_o,    32'h0);
    check("ar_bubble", bubble_o,    32'h1);
    rst_i = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register with integrated load-use hazard detection and branch flush.
- Sits between instruction fetch and decode.
- Drives the decode-side register-field and PC values, the PC write enable and the control-bubble select that zeroes control into the ID/EX register.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- CNT_W, 16, width of stall_cnt_o and flush_cnt_o counters.
- NOP_INST, 32'h00000000, instruction word loaded on reset and flush.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous active-low reset (0 = reset asserted)
pc_i  input  32  PC+4 from fetch
inst_i  input  32  instruction word from instruction memory
flush_i  input  1  taken branch/jump resolved in ID; discard fetched instruction
IDEX_MemRead_i  input  1  MemRead control currently held in ID/EX
IDEX_rt_i  input  5  destination rt of instruction currently in ID/EX
pc_o  output  32  registered PC+4 for decode and branch target adder
inst_o  output  32  registered instruction word
valid_o  output  1  1 = inst_o holds a real instruction, 0 = bubble
rs_o  output  5  inst_o[25:21]
rt_o  output  5  inst_o[20:16]
rd_o  output  5  inst_o[15:11]
imm_o  output  16  inst_o[15:0]
hazard_o  output  1  load-use hazard detected this cycle
PCWrite_o  output  1  PC update enable (inverse of hazard_o)
bubble_o  output  1  1 = decode control mux forces all control signals into ID/EX to 0
stall_cnt_o  output  CNT_W  count of hazard cycles, saturating
flush_cnt_o  output  CNT_W  count of flush cycles, saturating

Behaviour:
- Reset (rst_i=0, asynchronous, independent of clk_i):
  - pc_o=0, inst_o=NOP_INST, valid_o=0, stall_cnt_o=0, flush_cnt_o=0.
  - Reset asserted mid-stall or mid-flush clears everything immediately.
  - First capture happens on the first rising edge after rst_i returns to 1.
- Field outputs rs_o/rt_o/rd_o/imm_o are pure slices of registered inst_o: zero added latency, no extension.
- hazard_o (combinational from registered state and ID/EX inputs) = IDEX_MemRead_i & valid_o & (IDEX_rt_i != 0) & ((IDEX_rt_i == rs_o) | (IDEX_rt_i == rt_o)).
  - Comparison against rt_o is unconditional, independent of instruction type; a conservative stall is accepted.
- PCWrite_o = ~hazard_o. bubble_o = hazard_o | ~valid_o.
- Per-edge update, strict priority hazard > flush > normal:
  - hazard_o=1: pc_o, inst_o and valid_o hold. flush_i is ignored, because the branch in ID compared stale operands and re-resolves next cycle. stall_cnt_o increments.
  - flush_i=1, no hazard: pc_o<=pc_i, inst_o<=NOP_INST, valid_o<=0, flush_cnt_o increments.
  - normal: pc_o<=pc_i, inst_o<=inst_i, valid_o<=1.
- Latency: inst_i to inst_o is 1 cycle. A hazard inserts exactly 1 bubble: on the next cycle IDEX_MemRead_i falls because the bubble entered ID/EX, so hazard_o clears.
- Counters saturate at all-ones with no wrap. Both counters never increment on the same edge.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
- Reset, then release rst_i with pc_i=0x4, inst_i=0x8C220000 -> before edge valid_o=0, inst_o=0, bubble_o=1; after one edge pc_o=0x4, inst_o=0x8C220000, valid_o=1, rs_o=1, rt_o=2, imm_o=0.
- Load-use: inst_o=0x00430820 (add $1,$2,$3), IDEX_MemRead_i=1, IDEX_rt_i=2 -> hazard_o=1, PCWrite_o=0, bubble_o=1, inst_o held one edge, stall_cnt_o=1. IDEX_MemRead_i drops to 0 -> hazard_o=0, next edge loads inst_i.
- IDEX_rt_i=0 with MemRead=1 and rs_o=0 -> hazard_o=0, normal advance.
- flush_i=1, no hazard, inst_i=0x20010005 -> after edge inst_o=0, valid_o=0, pc_o=pc_i, flush_cnt_o=1.
- flush_i=1 together with hazard -> state held, flush_cnt_o unchanged, stall_cnt_o increments.
- Hold hazard 65540 cycles with CNT_W=16 -> stall_cnt_o sticks at 0xFFFF. Pulse rst_i low between edges -> all outputs return to reset values immediately.
